// File: rtl/ccd_cfg_pkg.sv
// Shared definitions for the CCD clock-generator serial configuration transmitter:
// register map, bit positions and frame sequencer states.
package ccd_cfg_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_FREQ   = 2'd1;
    localparam logic [1:0] REG_CLKDIV = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_START_BIT    = 1;
    localparam int STATUS_BUSY_BIT   = 0;
    localparam int STATUS_DONE_BIT   = 1;
    localparam int STATUS_FRAMES_LSB = 8;

    localparam int FRAME_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_SHIFT,
        ST_GAP
    } cfg_state_t;

endpackage

// File: rtl/ccd_cfg_serializer_if.sv
// Wishbone slave bus bundle used by the configuration transmitter.
interface ccd_cfg_serializer_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/ccd_cfg_clkdiv.sv
// Free-running config-clock divider: toggles every div+1 cycles while enabled and
// flags the cycle in which the toggle flop will rise or fall.
module ccd_cfg_clkdiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] div,
    output logic        cfg_clk,
    output logic        rise_pulse,
    output logic        fall_pulse
);

    logic [15:0] cnt;
    logic        reload;

    // Strobes mark the edge on which cfg_clk changes, so the sequencer updates in lockstep.
    assign reload     = enable && (cnt == 16'd0);
    assign rise_pulse = reload && !cfg_clk;
    assign fall_pulse = reload && cfg_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 16'd0;
            cfg_clk <= 1'b0;
        end else if (!enable) begin
            cnt     <= 16'd0;
            cfg_clk <= 1'b0;
        end else if (reload) begin
            cnt     <= div;
            cfg_clk <= ~cfg_clk;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end

endmodule

// File: rtl/ccd_cfg_serializer.sv
// Wishbone-programmable serial config transmitter: shifts a 4-bit frequency code MSB
// first to the CCD clock generator inside a 4-edge load window, then a latch gap.
module ccd_cfg_serializer
    import ccd_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100,
    parameter logic [15:0] CLKDIV_DEF   = 16'd4,
    parameter int          GAP_EDGES    = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    ccd_cfg_serializer_if.slave  bus,
    output logic                 o_cfg_clk,
    output logic                 o_cfg_enable,
    output logic                 o_cfg_data,
    output logic                 o_cfg_load,
    output logic                 o_busy
);

    logic        ctrl_enable;
    logic [3:0]  freq;
    logic [15:0] clkdiv;
    logic        done;
    logic [7:0]  frames;

    cfg_state_t  state;
    logic [3:0]  shift;
    logic [2:0]  bit_cnt;
    logic [7:0]  gap_cnt;
    logic        rise_pulse;
    logic        fall_pulse;

    logic        hit, req, wr;
    logic [1:0]  reg_sel;
    logic        lane0, lane1;
    logic        start_req, done_clr;
    logic [31:0] rdata;
    logic        unused_bits;

    assign hit       = (bus.wbs_adr_i[31:4] == BASE_ADDRESS[31:4]);
    assign req       = bus.wbs_stb_i && bus.wbs_cyc_i && hit && !bus.wbs_ack_o;
    assign wr        = req && bus.wbs_we_i;
    assign reg_sel   = bus.wbs_adr_i[3:2];
    assign lane0     = bus.wbs_sel_i[0];
    assign lane1     = bus.wbs_sel_i[1];
    assign start_req = wr && lane0 && (reg_sel == REG_CTRL) && bus.wbs_dat_i[CTRL_START_BIT];
    assign done_clr  = wr && lane0 && (reg_sel == REG_STATUS) && bus.wbs_dat_i[STATUS_DONE_BIT];
    assign unused_bits = ^{bus.wbs_dat_i[31:16], bus.wbs_adr_i[1:0], bus.wbs_sel_i[3:2]};

    assign o_cfg_enable = ctrl_enable;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL:   rdata[CTRL_ENABLE_BIT] = ctrl_enable;
            REG_FREQ:   rdata[3:0]             = freq;
            REG_CLKDIV: rdata[15:0]            = clkdiv;
            default: begin
                rdata[STATUS_BUSY_BIT]                        = o_busy;
                rdata[STATUS_DONE_BIT]                        = done;
                rdata[STATUS_FRAMES_LSB +: 8]                 = frames;
            end
        endcase
    end

    // The !ack term in req keeps a held strobe from producing back-to-back acks.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_dat_o <= 32'd0;
            ctrl_enable   <= 1'b0;
            freq          <= 4'd0;
            clkdiv        <= CLKDIV_DEF;
        end else begin
            bus.wbs_ack_o <= req;
            if (req && !bus.wbs_we_i)
                bus.wbs_dat_o <= rdata;
            if (wr && lane0) begin
                case (reg_sel)
                    REG_CTRL:   ctrl_enable  <= bus.wbs_dat_i[CTRL_ENABLE_BIT];
                    REG_FREQ:   freq         <= bus.wbs_dat_i[3:0];
                    REG_CLKDIV: clkdiv[7:0]  <= bus.wbs_dat_i[7:0];
                    default: ;
                endcase
            end
            if (wr && lane1 && (reg_sel == REG_CLKDIV))
                clkdiv[15:8] <= bus.wbs_dat_i[15:8];
        end
    end

    ccd_cfg_clkdiv u_clkdiv (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_n_i),
        .enable     (ctrl_enable),
        .div        (clkdiv),
        .cfg_clk    (o_cfg_clk),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // Frame completion is assigned after the W1C so a coincident clear loses to the set.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state      <= ST_IDLE;
            shift      <= 4'd0;
            bit_cnt    <= 3'd0;
            gap_cnt    <= 8'd0;
            o_cfg_data <= 1'b0;
            o_cfg_load <= 1'b0;
            o_busy     <= 1'b0;
            done       <= 1'b0;
            frames     <= 8'd0;
        end else begin
            if (done_clr)
                done <= 1'b0;
            if (!ctrl_enable) begin
                state      <= ST_IDLE;
                o_busy     <= 1'b0;
                o_cfg_data <= 1'b0;
                o_cfg_load <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start_req) begin
                        shift   <= freq;
                        bit_cnt <= 3'd0;
                        o_busy  <= 1'b1;
                        state   <= ST_ARM;
                    end
                    ST_ARM: if (fall_pulse) begin
                        o_cfg_data <= shift[3];
                        o_cfg_load <= 1'b1;
                        shift      <= {shift[2:0], 1'b0};
                        state      <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (rise_pulse) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (fall_pulse) begin
                            if (bit_cnt == 3'(FRAME_LEN)) begin
                                o_cfg_data <= 1'b0;
                                o_cfg_load <= 1'b0;
                                gap_cnt    <= 8'd0;
                                state      <= ST_GAP;
                            end else begin
                                o_cfg_data <= shift[3];
                                shift      <= {shift[2:0], 1'b0};
                            end
                        end
                    end
                    ST_GAP: if (rise_pulse) begin
                        if (gap_cnt == 8'(GAP_EDGES - 1)) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                            done   <= 1'b1;
                            frames <= frames + 8'd1;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccd_cfg_serializer.sv
// Bench for ccd_cfg_serializer: register table, hand-written frame/abort sequences and
// randomized frames checked by a behavioural model of the generator's serial receiver.
module tb_ccd_cfg_serializer;

    localparam logic [31:0] BASE     = 32'h3000_0100;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_FREQ   = BASE + 32'h4;
    localparam logic [31:0] A_CLKDIV = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;

    logic wb_clk_i   = 1'b0;
    logic wb_rst_n_i = 1'b1;
    logic o_cfg_clk, o_cfg_enable, o_cfg_data, o_cfg_load, o_busy;

    ccd_cfg_serializer_if bus();

    ccd_cfg_serializer #(
        .BASE_ADDRESS (BASE),
        .CLKDIV_DEF   (16'd4),
        .GAP_EDGES    (2)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_n_i   (wb_rst_n_i),
        .bus          (bus),
        .o_cfg_clk    (o_cfg_clk),
        .o_cfg_enable (o_cfg_enable),
        .o_cfg_data   (o_cfg_data),
        .o_cfg_load   (o_cfg_load),
        .o_busy       (o_busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic [31:0] adr;
        logic        do_write;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp;
        string       name;
    } reg_vec_t;

    reg_vec_t vecs[$];

    // Receiver model: shifts on config-clock rising edges while load is high and
    // latches the code on the first rising edge with load low; enable low resets it.
    int         rx_cnt = 0, rx_frames = 0, rx_edges_last = 0, launch_violations = 0;
    logic [3:0] rx_shift = 4'd0, rx_last = 4'd0;
    logic       prev_clk = 1'b0, prev_load = 1'b0, prev_data = 1'b0, prev_en = 1'b0;

    always @(negedge wb_clk_i) begin
        if (o_cfg_enable && prev_en && (o_cfg_load !== prev_load || o_cfg_data !== prev_data)
            && !(prev_clk && !o_cfg_clk))
            launch_violations++;
        if (!o_cfg_enable) begin
            rx_cnt = 0;
        end else if (o_cfg_clk && !prev_clk) begin
            if (o_cfg_load) begin
                rx_shift = {rx_shift[2:0], o_cfg_data};
                rx_cnt++;
            end else if (rx_cnt > 0) begin
                rx_last       = rx_shift;
                rx_edges_last = rx_cnt;
                rx_frames++;
                rx_cnt = 0;
            end
        end
        prev_clk  = o_cfg_clk;
        prev_load = o_cfg_load;
        prev_data = o_cfg_data;
        prev_en   = o_cfg_enable;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    function automatic logic [31:0] status_word(input int frames, input bit done_bit);
        logic [7:0] f;
        f = frames[7:0];
        return {16'h0, f, 6'b0, done_bit, 1'b0};
    endfunction

    task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                            input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
        int n = 0;
        bus.wbs_adr_i = adr;
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = wdat;
        bus.wbs_sel_i = sel;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        do begin
            @(posedge wb_clk_i); #1;
            n++;
        end while (!bus.wbs_ack_o && n < 8);
        acked = bus.wbs_ack_o;
        rdat  = bus.wbs_dat_o;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] r;
        logic a;
        wb_cycle(adr, 1'b1, dat, sel, r, a);
        check_output("wb_write_ack", a, 1);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
        logic a;
        wb_cycle(adr, 1'b0, 32'h0, 4'hF, dat, a);
        check_output("wb_read_ack", a, 1);
    endtask

    task automatic read_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_read(adr, r);
        check_output(name, r, exp);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        check_output("frame_complete", o_busy, 0);
    endtask

    task automatic wait_rx(input int edges);
        int n = 0;
        while (rx_cnt < edges && n < 300) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        check_output("rx_progress", rx_cnt >= edges, 1);
    endtask

    task automatic measure_clk(output int period, output int high_t);
        int n = 0;
        logic prev;
        prev = o_cfg_clk;
        while (!(o_cfg_clk && !prev) && n < 100) begin
            prev = o_cfg_clk;
            @(posedge wb_clk_i); #1;
            n++;
        end
        period = 0;
        high_t = 0;
        do begin
            if (o_cfg_clk) high_t++;
            period++;
            prev = o_cfg_clk;
            @(posedge wb_clk_i); #1;
        end while (!(o_cfg_clk && !prev) && period < 100);
    endtask

    task automatic apply_stimulus();
        logic [31:0] r;
        foreach (vecs[i]) begin
            if (vecs[i].do_write) wb_write(vecs[i].adr, vecs[i].wdata, vecs[i].sel);
            wb_read(vecs[i].adr, r);
            check_output(vecs[i].name, r, vecs[i].exp);
        end
    endtask

    initial begin
        int per, hi, acks, b2b, busy_seen, exp_frames;
        bit exp_done, prev_ack;
        logic [31:0] r;
        logic a;
        logic [3:0] f;
        logic [15:0] d;

        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_dat_i = 32'h0;
        bus.wbs_adr_i = 32'h0;

        vecs.push_back('{A_CLKDIV, 1'b0, 32'h0,         4'hF, 32'h0000_0004, "rst_clkdiv"});
        vecs.push_back('{A_STATUS, 1'b0, 32'h0,         4'hF, 32'h0000_0000, "rst_status"});
        vecs.push_back('{A_CTRL,   1'b0, 32'h0,         4'hF, 32'h0000_0000, "rst_ctrl"});
        vecs.push_back('{A_FREQ,   1'b0, 32'h0,         4'hF, 32'h0000_0000, "rst_freq"});
        vecs.push_back('{A_FREQ,   1'b1, 32'hFFFF_FFFA, 4'hF, 32'h0000_000A, "freq_mask"});
        vecs.push_back('{A_CLKDIV, 1'b1, 32'h1234_5678, 4'h1, 32'h0000_0078, "clkdiv_lane0"});
        vecs.push_back('{A_CLKDIV, 1'b1, 32'hAAAA_BBCC, 4'h2, 32'h0000_BB78, "clkdiv_lane1"});
        vecs.push_back('{A_CLKDIV, 1'b1, 32'h0000_0001, 4'h3, 32'h0000_0001, "clkdiv_both"});
        vecs.push_back('{A_CTRL,   1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, "ctrl_sel_none"});
        vecs.push_back('{A_STATUS, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, "status_ro"});
        vecs.push_back('{A_FREQ,   1'b1, 32'h0000_0005, 4'h2, 32'h0000_000A, "freq_lane1_ignored"});
        vecs.push_back('{A_CTRL,   1'b1, 32'h0000_0001, 4'h1, 32'h0000_0001, "ctrl_enable"});

        #1 wb_rst_n_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_n_i = 1'b1;
        check_output("rst_outputs", {o_cfg_clk, o_cfg_enable, o_cfg_data, o_cfg_load, o_busy}, 0);

        apply_stimulus();

        // Held strobe: acks must alternate rather than stay high
        bus.wbs_adr_i = A_CTRL; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'hF;
        bus.wbs_stb_i = 1'b1;   bus.wbs_cyc_i = 1'b1;
        acks = 0; b2b = 0; prev_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk_i); #1;
            if (bus.wbs_ack_o) acks++;
            if (bus.wbs_ack_o && prev_ack) b2b++;
            prev_ack = bus.wbs_ack_o;
        end
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
        check_output("ack_back_to_back", b2b, 0);
        check_output("ack_count_held_stb", acks, 3);

        repeat (10) @(posedge wb_clk_i); #1;
        measure_clk(per, hi);
        check_output("clk_period_div1", per, 4);
        check_output("clk_high_div1", hi, 2);
        wb_write(A_CLKDIV, 32'h0, 4'h3);
        repeat (10) @(posedge wb_clk_i); #1;
        measure_clk(per, hi);
        check_output("clk_period_div0", per, 2);
        check_output("clk_high_div0", hi, 1);
        wb_write(A_CLKDIV, 32'h1, 4'h3);

        wb_write(A_CTRL, 32'h0, 4'h0);
        read_check("ctrl_sel_none_enabled", A_CTRL, 32'h1);

        // First frame: code 0xA must arrive as 1,0,1,0 with load high for 4 edges
        wb_write(A_CTRL, 32'h3, 4'h1);
        check_output("busy_after_start", o_busy, 1);
        wait_idle(500);
        check_output("rx_code_A", rx_last, 4'hA);
        check_output("rx_load_edges", rx_edges_last, 4);
        check_output("rx_frames_1", rx_frames, 1);
        read_check("status_after_A", A_STATUS, status_word(1, 1'b1));

        wb_write(A_STATUS, 32'h2, 4'h1);
        read_check("status_w1c", A_STATUS, status_word(1, 1'b0));

        wb_write(A_CTRL, 32'h0, 4'h1);
        wb_write(A_CTRL, 32'h2, 4'h1);
        busy_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge wb_clk_i); #1;
            if (o_busy || o_cfg_load) busy_seen++;
        end
        check_output("start_disabled_idle", busy_seen, 0);
        check_output("start_disabled_rx", rx_frames, 1);
        read_check("start_disabled_status", A_STATUS, status_word(1, 1'b0));

        // START and FREQ writes during a frame must not disturb it
        wb_write(A_CTRL, 32'h1, 4'h1);
        wb_write(A_FREQ, 32'h6, 4'h1);
        wb_write(A_CTRL, 32'h3, 4'h1);
        wait_rx(1);
        wb_write(A_CTRL, 32'h3, 4'h1);
        wb_write(A_FREQ, 32'h9, 4'h1);
        wait_idle(500);
        repeat (60) @(posedge wb_clk_i); #1;
        check_output("busy_start_no_retrigger", o_busy, 0);
        check_output("busy_start_rx_code", rx_last, 4'h6);
        check_output("busy_start_rx_frames", rx_frames, 2);
        wb_write(A_CTRL, 32'h3, 4'h1);
        wait_idle(500);
        check_output("next_frame_new_freq", rx_last, 4'h9);
        read_check("status_frames_3", A_STATUS, status_word(3, 1'b1));

        wb_cycle(BASE + 32'h10, 1'b0, 32'h0, 4'hF, r, a);
        check_output("unmapped_high_no_ack", a, 0);
        check_output("unmapped_dat_kept", r, status_word(3, 1'b1));
        wb_cycle(BASE - 32'h4, 1'b1, 32'h3, 4'hF, r, a);
        check_output("unmapped_low_no_ack", a, 0);
        check_output("unmapped_no_start", o_busy, 0);

        // Abort after two data edges
        wb_write(A_STATUS, 32'h2, 4'h1);
        wb_write(A_FREQ, 32'hF, 4'h1);
        wb_write(A_CTRL, 32'h3, 4'h1);
        wait_rx(2);
        wb_write(A_CTRL, 32'h0, 4'h1);
        @(posedge wb_clk_i); #1;
        check_output("abort_outputs", {o_busy, o_cfg_load, o_cfg_clk, o_cfg_data}, 0);
        read_check("abort_status", A_STATUS, status_word(3, 1'b0));
        check_output("abort_rx_frames", rx_frames, 3);
        wb_write(A_CTRL, 32'h1, 4'h1);
        wb_write(A_FREQ, 32'h5, 4'h1);
        wb_write(A_CTRL, 32'h3, 4'h1);
        wait_idle(500);
        check_output("reenable_rx_code", rx_last, 4'h5);
        check_output("reenable_rx_edges", rx_edges_last, 4);
        read_check("reenable_status", A_STATUS, status_word(4, 1'b1));

        exp_frames = 4;
        exp_done   = 1'b1;
        for (int it = 0; it < 8; it++) begin
            f = 4'($urandom_range(0, 15));
            d = 16'($urandom_range(0, 2));
            wb_write(A_CLKDIV, {16'h0, d}, 4'h3);
            wb_write(A_FREQ, {28'h0, f}, 4'h1);
            if ($urandom_range(0, 1) == 1) begin
                wb_write(A_STATUS, 32'h2, 4'h1);
                exp_done = 1'b0;
                read_check("rnd_status_cleared", A_STATUS, status_word(exp_frames, exp_done));
            end
            wb_write(A_CTRL, 32'h3, 4'h1);
            if ($urandom_range(0, 1) == 1) begin
                wait_rx(1);
                wb_write(A_FREQ, {28'h0, ~f}, 4'h1);
            end
            wait_idle(800);
            exp_frames++;
            exp_done = 1'b1;
            check_output("rnd_rx_code", rx_last, f);
            check_output("rnd_rx_edges", rx_edges_last, 4);
            check_output("rnd_rx_frames", rx_frames, exp_frames);
            read_check("rnd_status", A_STATUS, status_word(exp_frames, exp_done));
        end

        // Asynchronous reset in the middle of a frame
        wb_write(A_FREQ, 32'h3, 4'h1);
        wb_write(A_CTRL, 32'h3, 4'h1);
        wait_rx(2);
        #3 wb_rst_n_i = 1'b0;
        #1;
        check_output("reset_mid_frame_outputs",
                     {o_cfg_clk, o_cfg_enable, o_cfg_data, o_cfg_load, o_busy}, 0);
        @(posedge wb_clk_i); #1 wb_rst_n_i = 1'b1;
        read_check("reset_mid_frame_status", A_STATUS, 32'h0);
        read_check("reset_mid_frame_clkdiv", A_CLKDIV, 32'h4);
        check_output("reset_mid_frame_rx", rx_frames, exp_frames);

        check_output("launch_on_falling_only", launch_violations, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
